// File: rtl/bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_bram_pkg
// Description : Shared types and helpers for the BRAM arbiter slice.
//               arb_state_t - arbiter FSM state encoding
//               id_width()  - width of a requester index (minimum 1 bit)
// Revision    : 1.0 - initial release
// ============================================================================
package nn_bram_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // A single requester still needs a 1-bit index so vectors never collapse
  // to zero width.
  function automatic int id_width(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter_if
// Description : Requester-side bundle of the BRAM arbiter. One valid/ready
//               request channel per requester (packed vectors) plus the
//               one-hot read-response strobe and the shared read data.
//   master : requester side (drives valid/wr/lock/addr/wdata)
//   slave  : arbiter side   (drives ready/rsp_valid/rsp_data)
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_arbiter_if #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_LEN = 32,
  parameter int WORD_LEN = 32
);
  localparam int c_aw = $clog2(ADDR_LEN);

  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic [NUM_REQ-1:0]          req_wr_i;
  logic [NUM_REQ-1:0]          req_lock_i;
  logic [NUM_REQ*c_aw-1:0]     req_addr_i;
  logic [NUM_REQ*WORD_LEN-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]          rsp_valid_o;
  logic [WORD_LEN-1:0]         rsp_data_o;

  modport master (
    output req_valid_i, req_wr_i, req_lock_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_wr_i, req_lock_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );

endinterface
`default_nettype wire

// File: rtl/bram_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin pick: first set bit of i_req at or
//               after i_ptr, wrapping past the top requester.
//   i_req   : request vector
//   i_ptr   : search start index
//   o_grant : one-hot grant (zero when nothing requests)
//   o_idx   : binary index of the granted requester
//   o_any   : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
  import nn_bram_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]               i_req,
  input  logic [id_width(NUM_REQ)-1:0]     i_ptr,
  output logic [NUM_REQ-1:0]               o_grant,
  output logic [id_width(NUM_REQ)-1:0]     o_idx,
  output logic                             o_any
);

  localparam int c_iw = id_width(NUM_REQ);

  int              w_sum;
  logic [c_iw-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = 0;
    w_pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Wrap without a modulo operator: ptr + i never exceeds 2*NUM_REQ-2.
      w_sum = int'(i_ptr) + i;
      if (w_sum >= NUM_REQ) begin
        w_sum = w_sum - NUM_REQ;
      end
      w_pos = c_iw'(w_sum);
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter
// Description : Round-robin arbiter sharing one single-port BRAM between
//               NUM_REQ requesters, with an optional grant lock for bursts.
//               Accepted beats are registered onto the BRAM port; read data
//               is routed back through a tag pipeline to the issuer.
//   clk_i / reset_ni : clock, asynchronous active-low reset
//   req_bus (slave)  : per-requester request channels and read responses
//   bram_ena_o       : BRAM enable, one cycle per accepted beat
//   bram_wr_ena_o    : BRAM write enable
//   bram_addr_o      : BRAM address
//   bram_data_o      : BRAM write data
//   bram_data_i      : BRAM read data, valid RD_LATENCY after bram_ena_o
// Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter
  import nn_bram_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_LEN   = 32,
  parameter int WORD_LEN   = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  bram_arbiter_if.slave               req_bus,
  output logic                        bram_ena_o,
  output logic                        bram_wr_ena_o,
  output logic [$clog2(ADDR_LEN)-1:0] bram_addr_o,
  output logic [WORD_LEN-1:0]         bram_data_o,
  input  logic [WORD_LEN-1:0]         bram_data_i
);

  localparam int              c_aw      = $clog2(ADDR_LEN);
  localparam int              c_iw      = id_width(NUM_REQ);
  localparam logic [c_iw-1:0] c_last_id = c_iw'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_one  = NUM_REQ'(1);

  arb_state_t          r_state, w_state_nxt;
  logic [c_iw-1:0]     r_owner, w_owner_nxt;
  logic [c_iw-1:0]     r_rr_ptr, w_rr_ptr_nxt;

  logic [NUM_REQ-1:0]  w_pick_grant;
  logic [c_iw-1:0]     w_pick_idx;
  logic                w_pick_any;

  logic [NUM_REQ-1:0]  w_ready;
  logic                w_accept;
  logic [c_iw-1:0]     w_acc_idx;
  logic                w_acc_wr;
  logic [c_aw-1:0]     w_acc_addr;
  logic [WORD_LEN-1:0] w_acc_wdata;

  logic                r_bram_ena;
  logic                r_bram_wr;
  logic [c_aw-1:0]     r_bram_addr;
  logic [WORD_LEN-1:0] r_bram_data;

  // Stage 0 lines up with the registered BRAM port; the last stage lines up
  // with valid read data on bram_data_i.
  logic [RD_LATENCY:0] r_tag_vld;
  logic [c_iw-1:0]     r_tag_id [RD_LATENCY+1];

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req   (req_bus.req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // --------------------------------------------------------------------------
  // FSM: next state, grant and pointer update
  // --------------------------------------------------------------------------
  always_comb begin
    w_ready      = '0;
    w_acc_idx    = r_owner;
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;

    // Ready is forced low while reset is held so nothing looks granted.
    if (reset_ni) begin
      case (r_state)
        ARB: begin
          if (w_pick_any) begin
            w_ready   = w_pick_grant;
            w_acc_idx = w_pick_idx;
          end
        end
        LOCKED: begin
          // Owner keeps the grant even while its valid is low.
          w_ready = c_one << r_owner;
        end
        default: ;
      endcase
    end

    w_accept = |(req_bus.req_valid_i & w_ready);

    if (w_accept) begin
      if (req_bus.req_lock_i[w_acc_idx]) begin
        w_state_nxt = LOCKED;
        w_owner_nxt = w_acc_idx;
      end else begin
        w_state_nxt  = ARB;
        w_rr_ptr_nxt = (w_acc_idx == c_last_id) ? '0 : w_acc_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state  <= ARB;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Payload mux and registered BRAM port
  // --------------------------------------------------------------------------
  always_comb begin
    w_acc_wr    = req_bus.req_wr_i[w_acc_idx];
    w_acc_addr  = req_bus.req_addr_i[int'(w_acc_idx)*c_aw +: c_aw];
    w_acc_wdata = req_bus.req_wdata_i[int'(w_acc_idx)*WORD_LEN +: WORD_LEN];
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_bram_ena  <= 1'b0;
      r_bram_wr   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_data <= '0;
    end else begin
      r_bram_ena <= w_accept;
      r_bram_wr  <= w_accept & w_acc_wr;
      if (w_accept) begin
        r_bram_addr <= w_acc_addr;
        r_bram_data <= w_acc_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read tag pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_tag_vld <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        r_tag_id[i] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_accept & ~w_acc_wr;
      r_tag_id[0]  <= w_acc_idx;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign req_bus.req_ready_o = w_ready;
  assign req_bus.rsp_valid_o = r_tag_vld[RD_LATENCY] ? (c_one << r_tag_id[RD_LATENCY]) : '0;
  // Data is gated so the shared bus reads zero whenever no response is due.
  assign req_bus.rsp_data_o  = r_tag_vld[RD_LATENCY] ? bram_data_i : '0;

  assign bram_ena_o    = r_bram_ena;
  assign bram_wr_ena_o = r_bram_wr;
  assign bram_addr_o   = r_bram_addr;
  assign bram_data_o   = r_bram_data;

endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_arbiter
// Description : Directed self-checking bench for bram_arbiter (2 requesters,
//               32 x 32-bit BRAM, read latency 1) with a behavioural BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_arbiter;

  logic        clk;
  logic        reset_ni;
  logic        bram_ena;
  logic        bram_wr_ena;
  logic [4:0]  bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata = 32'h0;
  logic [31:0] mem [32];

  int n_checks;
  int n_errors;

  bram_arbiter_if #(.NUM_REQ(2), .ADDR_LEN(32), .WORD_LEN(32)) bus ();

  bram_arbiter #(
    .NUM_REQ    (2),
    .ADDR_LEN   (32),
    .WORD_LEN   (32),
    .RD_LATENCY (1)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_ni),
    .req_bus       (bus),
    .bram_ena_o    (bram_ena),
    .bram_wr_ena_o (bram_wr_ena),
    .bram_addr_o   (bram_addr),
    .bram_data_o   (bram_wdata),
    .bram_data_i   (bram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM, one cycle read latency.
  always @(posedge clk) begin
    if (bram_ena) begin
      if (bram_wr_ena) mem[bram_addr] = bram_wdata;
      else             bram_rdata <= mem[bram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic wr, input logic lock,
                       input logic [4:0] addr, input logic [31:0] wdata);
    bus.req_valid_i[k]          = v;
    bus.req_wr_i[k]             = wr;
    bus.req_lock_i[k]           = lock;
    bus.req_addr_i[k*5 +: 5]    = addr;
    bus.req_wdata_i[k*32 +: 32] = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[3] = 32'hDEADBEEF;
    mem[4] = 32'h000000A0;
    mem[5] = 32'h000000B1;

    // ---------------- reset with all valids high ----------------
    reset_ni        = 1'b0;
    bus.req_valid_i = '0;
    bus.req_wr_i    = '0;
    bus.req_lock_i  = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    drive(0, 1, 0, 0, 5'd1, 32'h0);
    drive(1, 1, 0, 0, 5'd2, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_ready",     bus.req_ready_o, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid_o, 2'b00);
    check("rst_rsp_data",  bus.rsp_data_o,  32'h0);
    check("rst_ena",       bram_ena,        1'b0);
    check("rst_wr_ena",    bram_wr_ena,     1'b0);
    check("rst_addr",      bram_addr,       5'd0);
    check("rst_wdata",     bram_wdata,      32'h0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    @(negedge clk);
    check("first_grant", bus.req_ready_o, 2'b01);
    drive(0, 0, 0, 0, 5'd0, 32'h0);
    drive(1, 0, 0, 0, 5'd0, 32'h0);
    #1;
    check("idle_ready", bus.req_ready_o, 2'b00);

    // ---------------- read latency ----------------
    next_cycle();
    drive(1, 1, 0, 0, 5'd3, 32'h0);
    @(negedge clk);
    check("lat_ready", bus.req_ready_o, 2'b10);
    next_cycle();
    drive(1, 0, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    check("lat_ena",       bram_ena,        1'b1);
    check("lat_wr_ena",    bram_wr_ena,     1'b0);
    check("lat_addr",      bram_addr,       5'd3);
    check("lat_rsp_early", bus.rsp_valid_o, 2'b00);
    @(negedge clk);
    check("lat_rsp_valid", bus.rsp_valid_o, 2'b10);
    check("lat_rsp_data",  bus.rsp_data_o,  32'hDEADBEEF);
    check("lat_ena_idle",  bram_ena,        1'b0);

    // ---------------- round robin ----------------
    next_cycle();
    drive(0, 1, 0, 0, 5'd4, 32'h0);
    drive(1, 1, 0, 0, 5'd5, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) check("rr_ready", bus.req_ready_o, exp_gnt[i]);
      if (i >= 2) begin
        check("rr_rsp_valid", bus.rsp_valid_o, exp_gnt[i-2]);
        check("rr_rsp_data", bus.rsp_data_o,
              (exp_gnt[i-2] == 2'b01) ? 32'h000000A0 : 32'h000000B1);
      end else begin
        check("rr_rsp_idle", bus.rsp_valid_o, 2'b00);
      end
      next_cycle();
      if (i == 3) begin
        drive(0, 0, 0, 0, 5'd0, 32'h0);
        drive(1, 0, 0, 0, 5'd0, 32'h0);
      end
    end

    // ---------------- lock burst ----------------
    drive(0, 1, 1, 1, 5'd0, 32'h100);
    drive(1, 1, 0, 0, 5'd5, 32'h0);
    @(negedge clk);
    check("lk_a_ready", bus.req_ready_o, 2'b01);
    next_cycle();
    drive(0, 0, 1, 1, 5'd1, 32'h101);
    @(negedge clk);
    check("lk_b_ready", bus.req_ready_o, 2'b01);
    check("lk_b_ena",   bram_ena,        1'b1);
    check("lk_b_wr",    bram_wr_ena,     1'b1);
    check("lk_b_addr",  bram_addr,       5'd0);
    check("lk_b_wdata", bram_wdata,      32'h100);
    next_cycle();
    @(negedge clk);
    check("lk_c_ready", bus.req_ready_o, 2'b01);
    check("lk_c_ena",   bram_ena,        1'b0);
    next_cycle();
    drive(0, 1, 1, 1, 5'd1, 32'h101);
    @(negedge clk);
    check("lk_d_ready", bus.req_ready_o, 2'b01);
    next_cycle();
    drive(0, 1, 1, 0, 5'd2, 32'h102);
    @(negedge clk);
    check("lk_e_ready", bus.req_ready_o, 2'b01);
    check("lk_e_addr",  bram_addr,       5'd1);
    check("lk_e_wdata", bram_wdata,      32'h101);
    next_cycle();
    drive(0, 0, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    check("lk_f_ready", bus.req_ready_o, 2'b10);
    check("lk_f_addr",  bram_addr,       5'd2);
    check("lk_f_wdata", bram_wdata,      32'h102);
    next_cycle();
    drive(1, 0, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    check("lk_g_ena",  bram_ena,    1'b1);
    check("lk_g_wr",   bram_wr_ena, 1'b0);
    check("lk_g_addr", bram_addr,   5'd5);
    @(negedge clk);
    check("lk_rsp_valid", bus.rsp_valid_o, 2'b10);
    check("lk_rsp_data",  bus.rsp_data_o,  32'h000000B1);

    // ---------------- write then read ----------------
    next_cycle();
    drive(0, 1, 1, 0, 5'd7, 32'h12345678);
    drive(1, 1, 0, 0, 5'd7, 32'h0);
    @(negedge clk);
    check("wtr_ready_wr", bus.req_ready_o, 2'b01);
    next_cycle();
    drive(0, 0, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    check("wtr_ready_rd", bus.req_ready_o, 2'b10);
    next_cycle();
    drive(1, 0, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    check("wtr_ena",  bram_ena,    1'b1);
    check("wtr_wr",   bram_wr_ena, 1'b0);
    check("wtr_addr", bram_addr,   5'd7);
    @(negedge clk);
    check("wtr_rsp_valid", bus.rsp_valid_o, 2'b10);
    check("wtr_rsp_data",  bus.rsp_data_o,  32'h12345678);

    // ---------------- reset mid-operation ----------------
    next_cycle();
    drive(0, 1, 1, 0, 5'd9, 32'h55);
    @(negedge clk);
    check("mr_wr_ready", bus.req_ready_o, 2'b01);
    next_cycle();
    drive(0, 0, 0, 0, 5'd0, 32'h0);
    drive(1, 1, 0, 1, 5'd3, 32'h0);
    @(negedge clk);
    check("mr_rd_ready", bus.req_ready_o, 2'b10);
    next_cycle();
    drive(1, 0, 0, 0, 5'd0, 32'h0);
    reset_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mr_rsp_in_reset", bus.rsp_valid_o, 2'b00);
      check("mr_ena_in_reset", bram_ena,        1'b0);
    end
    next_cycle();
    reset_ni = 1'b1;
    drive(0, 1, 0, 0, 5'd0, 32'h0);
    drive(1, 1, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    check("mr_ready_after", bus.req_ready_o, 2'b01);
    drive(0, 0, 0, 0, 5'd0, 32'h0);
    drive(1, 0, 0, 0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_rsp_after", bus.rsp_valid_o, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
